jtframe_sdram_rsp: RTL and testbench



---
 rtl/jtframe_sdram_rsp.sv | 122 ++++++++++++
 tb/tb_jtframe_sdram_rsp.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sdram_rsp.sv
// SDRAM-side responder for the jtframe ROM arbiter and download loader.
// Serves burst reads and byte writes from a fixed-latency synchronous 16-bit memory port.
module jtframe_sdram_rsp #(
  parameter int AW      = 22,
  parameter int LATENCY = 2,
  parameter int BURST   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic          sdram_req,
  input  logic [AW-1:0] sdram_addr,
  output logic          sdram_ack,
  output logic          data_dst,
  output logic          data_rdy,
  output logic [15:0]   data_read,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [1:0]    prog_mask,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_be,
  input  logic [15:0]   mem_dout
);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_WAIT} state_t;

  localparam int CW = $clog2(BURST + 1);

  state_t             state;
  logic [CW-1:0]      iss_cnt;
  logic [CW-1:0]      ret_cnt;
  logic               rd_first;
  logic [LATENCY-1:0] rd_pipe;
  logic [LATENCY-1:0] first_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the return pipeline is reset too, so no word issued before reset can surface as data_rdy after release.
      state      <= IDLE;
      iss_cnt    <= '0;
      ret_cnt    <= '0;
      rd_first   <= 1'b0;
      rd_pipe    <= '0;
      first_pipe <= '0;
      sdram_ack  <= 1'b0;
      data_dst   <= 1'b0;
      data_rdy   <= 1'b0;
      data_read  <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_din    <= '0;
      mem_be     <= '0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the FSM below overrides them for this edge.
      sdram_ack <= 1'b0;
      rd_first  <= 1'b0;

      // Track each mem_rd for LATENCY cycles so its word is captured exactly when mem_dout is valid.
      rd_pipe[0]    <= mem_rd;
      first_pipe[0] <= rd_first;
      for (int i = 1; i < LATENCY; i++) begin
        rd_pipe[i]    <= rd_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
      end

      data_rdy <= rd_pipe[LATENCY-1];
      data_dst <= first_pipe[LATENCY-1];
      if (rd_pipe[LATENCY-1]) begin
        data_read <= mem_dout;
        ret_cnt   <= ret_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (downloading) begin
            if (prog_we) begin
              sdram_ack <= 1'b1;
              mem_wr    <= 1'b1;
              mem_addr  <= prog_addr;
              mem_din   <= {prog_data, prog_data};
              mem_be    <= ~prog_mask;
              state     <= WR;
            end
          end else if (sdram_req) begin
            sdram_ack <= 1'b1;
            mem_rd    <= 1'b1;
            rd_first  <= 1'b1;
            mem_addr  <= sdram_addr;
            iss_cnt   <= CW'(1);
            ret_cnt   <= '0;
            state     <= RD_ISSUE;
          end
        end
        WR: begin
          mem_wr <= 1'b0;
          mem_be <= '0;
          state  <= IDLE;
        end
        RD_ISSUE: begin
          if (iss_cnt == CW'(BURST)) begin
            mem_rd <= 1'b0;
            state  <= RD_WAIT;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            iss_cnt  <= iss_cnt + 1'b1;
          end
        end
        RD_WAIT: begin
          // Leave only once the last word has been presented on data_read.
          if (ret_cnt == CW'(BURST)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_rsp.sv
// Scoreboard bench for jtframe_sdram_rsp: directed stimulus pushes expectations,
// a monitor pops and compares them whenever the DUT drives ack, mem_rd, mem_wr or data_rdy.
module tb_jtframe_sdram_rsp;

  localparam int AW  = 22;
  localparam int LAT = 2;
  localparam int BUR = 2;

  logic          clk;
  logic          rst_n;
  logic          downloading;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          data_dst;
  logic          data_rdy;
  logic [15:0]   data_read;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [1:0]    prog_mask;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_be;
  logic [15:0]   mem_dout;

  jtframe_sdram_rsp #(.AW(AW), .LATENCY(LAT), .BURST(BUR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_dst    (data_dst),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_din     (mem_din),
    .mem_be      (mem_be),
    .mem_dout    (mem_dout)
  );

  typedef struct {
    logic [15:0] d;
    logic        dst;
    int          cyc;
  } rd_exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   din;
    logic [1:0]    be;
    int            cyc;
  } wr_exp_t;

  rd_exp_t       rdq[$];
  wr_exp_t       wrq[$];
  int            ackq[$];
  logic [AW-1:0] addrq[$];

  int checks  = 0;
  int errors  = 0;
  int rdy_cnt = 0;
  int wr_cnt  = 0;
  int ack_cnt = 0;
  int cyc     = 0;

  logic [15:0] mem [logic [AW-1:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_get(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'hDEAD;
  endfunction

  // Memory model with LAT=2: data for a mem_rd seen in cycle n is driven during cycle n+2.
  logic [AW-1:0] a1;
  logic          rd1;
  logic [15:0]   dout_r;
  always @(posedge clk) begin
    rd1    <= mem_rd;
    a1     <= mem_addr;
    dout_r <= rd1 ? mem_get(a1) : 16'hDEAD;
  end
  assign mem_dout = dout_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every DUT event against the head of its scoreboard queue.
  initial begin : monitor
    rd_exp_t     e;
    wr_exp_t     w;
    logic [15:0] last_data;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_data = '0;
        continue;
      end
      check("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      if (sdram_ack) begin
        ack_cnt++;
        if (ackq.size() == 0) check("ack_unexpected", {31'd0, sdram_ack}, 32'd0);
        else check("ack_cycle", cyc, ackq.pop_front());
      end
      if (mem_rd) begin
        if (addrq.size() == 0) check("rd_unexpected", {31'd0, mem_rd}, 32'd0);
        else check("rd_addr", {10'd0, mem_addr}, {10'd0, addrq.pop_front()});
      end
      if (mem_wr) begin
        wr_cnt++;
        if (wrq.size() == 0) check("wr_unexpected", {31'd0, mem_wr}, 32'd0);
        else begin
          w = wrq.pop_front();
          check("wr_addr", {10'd0, mem_addr}, {10'd0, w.a});
          check("wr_din", {16'd0, mem_din}, {16'd0, w.din});
          check("wr_be", {30'd0, mem_be}, {30'd0, w.be});
          check("wr_cycle", cyc, w.cyc);
        end
      end
      if (data_rdy) begin
        rdy_cnt++;
        if (rdq.size() == 0) check("rdy_unexpected", {31'd0, data_rdy}, 32'd0);
        else begin
          e = rdq.pop_front();
          check("rd_data", {16'd0, data_read}, {16'd0, e.d});
          check("rd_dst", {31'd0, data_dst}, {31'd0, e.dst});
          check("rd_cycle", cyc, e.cyc);
          last_data = e.d;
        end
      end else begin
        check("data_hold", {16'd0, data_read}, {16'd0, last_data});
        check("dst_idle", {31'd0, data_dst}, 32'd0);
      end
    end
  end

  // Expectations for a read sampled at the edge closing cycle t (LAT=2, BURST=2).
  task automatic push_read(input int t, input logic [AW-1:0] a, input logic [15:0] w0, input logic [15:0] w1);
    rd_exp_t       e;
    logic [AW-1:0] an;
    an = a + 1'b1;
    ackq.push_back(t + 1);
    addrq.push_back(a);
    addrq.push_back(an);
    e.d = w0; e.dst = 1'b1; e.cyc = t + 4; rdq.push_back(e);
    e.d = w1; e.dst = 1'b0; e.cyc = t + 5; rdq.push_back(e);
  endtask

  task automatic push_write(input int c, input logic [AW-1:0] a, input logic [15:0] din, input logic [1:0] be);
    wr_exp_t w;
    w.a = a; w.din = din; w.be = be; w.cyc = c;
    ackq.push_back(c);
    wrq.push_back(w);
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sdram_ack && n < budget);
    if (!sdram_ack) check(name, {31'd0, sdram_ack}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {26'd0, sdram_ack, data_dst, data_rdy, mem_rd, mem_wr, mem_be[1]}, 32'd0);
    check({tag, "_data"}, {data_read, mem_din}, 32'd0);
    check({tag, "_addr"}, {9'd0, mem_be[0], mem_addr}, 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int t, w0, a0, r0;
    rst_n       = 1'b1;
    downloading = 1'b0;
    sdram_req   = 1'b0;
    sdram_addr  = '0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    prog_mask   = 2'b11;
    mem[22'h000100] = 16'h1234;
    mem[22'h000101] = 16'hBEEF;
    mem[22'h000102] = 16'hC0DE;
    mem[22'h3FFFFF] = 16'h0F0F;
    mem[22'h000000] = 16'h7777;
    mem[22'h000040] = 16'h4444;
    mem[22'h000041] = 16'h5555;
    mem[22'h000200] = 16'hA0A0;
    mem[22'h000201] = 16'hA1A1;
    mem[22'h000300] = 16'hB0B0;
    mem[22'h000301] = 16'hB1B1;
    #2 rst_n = 1'b0;
    idle(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Basic burst read
    t = cyc;
    push_read(t, 22'h000100, 16'h1234, 16'hBEEF);
    sdram_addr = 22'h000100;
    sdram_req  = 1'b1;
    wait_ack("read_ack_timeout", 6);
    sdram_req = 1'b0;
    idle(8);

    // Address wrap, with downloading toggled mid-burst
    t = cyc;
    push_read(t, 22'h3FFFFF, 16'h0F0F, 16'h7777);
    sdram_addr = 22'h3FFFFF;
    sdram_req  = 1'b1;
    wait_ack("wrap_ack_timeout", 6);
    sdram_req   = 1'b0;
    downloading = 1'b1;
    idle(2);
    downloading = 1'b0;
    idle(6);

    // Single download write
    w0 = wr_cnt;
    downloading = 1'b1;
    prog_addr   = 22'h000010;
    prog_data   = 8'hA5;
    prog_mask   = 2'b10;
    t = cyc;
    push_write(t + 1, 22'h000010, 16'hA5A5, 2'b01);
    prog_we = 1'b1;
    wait_ack("write_ack_timeout", 6);
    prog_we = 1'b0;
    idle(4);
    check("write_count_single", wr_cnt, w0 + 1);

    // prog_we held across two writes: second one two cycles after the first
    w0 = wr_cnt;
    prog_addr = 22'h000020;
    prog_data = 8'h3C;
    prog_mask = 2'b00;
    t = cyc;
    push_write(t + 1, 22'h000020, 16'h3C3C, 2'b11);
    push_write(t + 3, 22'h000020, 16'h3C3C, 2'b11);
    prog_we = 1'b1;
    wait_ack("write1_ack_timeout", 6);
    wait_ack("write2_ack_timeout", 6);
    prog_we = 1'b0;
    idle(4);
    check("write_count_held", wr_cnt, w0 + 2);
    downloading = 1'b0;

    // prog_we while not downloading is ignored
    w0 = wr_cnt;
    prog_we = 1'b1;
    idle(10);
    prog_we = 1'b0;
    check("write_ignored", wr_cnt, w0);

    // Read gated while downloading, then served within 2 cycles
    a0 = ack_cnt;
    downloading = 1'b1;
    sdram_addr  = 22'h000040;
    sdram_req   = 1'b1;
    idle(20);
    check("gate_no_ack", ack_cnt, a0);
    t = cyc;
    push_read(t, 22'h000040, 16'h4444, 16'h5555);
    downloading = 1'b0;
    wait_ack("gate_release_ack", 2);
    sdram_req = 1'b0;
    idle(8);

    // Back-to-back with req held: second ack two cycles after the first burst ends
    t = cyc;
    push_read(t,     22'h000200, 16'hA0A0, 16'hA1A1);
    push_read(t + 6, 22'h000300, 16'hB0B0, 16'hB1B1);
    sdram_addr = 22'h000200;
    sdram_req  = 1'b1;
    wait_ack("b2b_ack1_timeout", 6);
    sdram_addr = 22'h000300;
    wait_ack("b2b_ack2_timeout", 10);
    sdram_req = 1'b0;
    idle(8);

    // Asynchronous reset in the middle of a burst
    t = cyc;
    push_read(t, 22'h000100, 16'h1234, 16'hBEEF);
    sdram_addr = 22'h000100;
    sdram_req  = 1'b1;
    wait_ack("rst_read_ack_timeout", 6);
    sdram_req = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("midburst_reset");
    r0 = rdy_cnt;
    rdq.delete();
    addrq.delete();
    ackq.delete();
    idle(3);
    rst_n = 1'b1;
    idle(10);
    check("no_stale_rdy", rdy_cnt, r0);

    // Fresh read after reset release
    t = cyc;
    push_read(t, 22'h000101, 16'hBEEF, 16'hC0DE);
    sdram_addr = 22'h000101;
    sdram_req  = 1'b1;
    wait_ack("post_reset_ack_timeout", 6);
    sdram_req = 1'b0;
    idle(8);

    check("rdq_drained", rdq.size(), 32'd0);
    check("wrq_drained", wrq.size(), 32'd0);
    check("ackq_drained", ackq.size(), 32'd0);
    check("addrq_drained", addrq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
